// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter/sequencer sharing one RF register interface
// among up to four requesters, one access in flight at a time.
module rf_access_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int SETUP_CYC = 2,
  parameter int MIN_WAIT  = 3,
  parameter int TIMEOUT   = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*10-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]  req_data,
  input  logic [NUM_REQ*2-1:0]  req_inst,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [7:0]            rsp_data,
  output logic                  rsp_err,
  output logic [9:0]            rf_addr,
  output logic [7:0]            rf_data,
  output logic [1:0]            rf_inst,
  output logic                  rf_cs,
  input  logic                  rf_ready,
  input  logic [7:0]            rf_rdata,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [1:0]         last_q, last_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [2:0]         scnt_q, scnt_d;
  logic [9:0]         wcnt_q, wcnt_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [9:0]         rf_addr_q, rf_addr_d;
  logic [7:0]         rf_data_q, rf_data_d;
  logic [1:0]         rf_inst_q, rf_inst_d;
  logic               rf_cs_q, rf_cs_d;
  logic               busy_q, busy_d;

  logic       found;
  logic [1:0] gnt;
  logic [9:0] sel_addr;
  logic [7:0] sel_data;
  logic [1:0] sel_inst;

  // Round-robin pick: smallest offset from last_grant+1 wins.
  always_comb begin
    found    = 1'b0;
    gnt      = '0;
    sel_addr = '0;
    sel_data = '0;
    sel_inst = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (k == (int'(last_q) + 1 + off) % NUM_REQ
            && req_valid[k]) begin
          found    = 1'b1;
          gnt      = 2'(k);
          sel_addr = req_addr[10*k +: 10];
          sel_data = req_data[8*k +: 8];
          sel_inst = req_inst[2*k +: 2];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    scnt_d      = scnt_q;
    wcnt_d      = wcnt_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_data_d   = rf_data_q;
    rf_inst_d   = rf_inst_q;
    rf_cs_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d   = S_SETUP;
          gnt_d     = gnt;
          last_d    = gnt;
          scnt_d    = '0;
          rf_data_d = sel_data;
          rf_inst_d = sel_inst;
          rf_addr_d = sel_inst[1] ? sel_addr
                                  : {4'b0, sel_addr[5:0]};
          for (int k = 0; k < NUM_REQ; k++)
            if (2'(k) == gnt) req_ready_d[k] = 1'b1;
        end
      end
      S_SETUP: begin
        if (scnt_q == 3'(SETUP_CYC - 1)) begin
          state_d = S_STROBE;
          rf_cs_d = 1'b1;
        end else begin
          scnt_d = scnt_q + 3'd1;
        end
      end
      S_STROBE: begin
        state_d = S_WAIT;
        wcnt_d  = '0;
      end
      S_WAIT: begin
        if (wcnt_q >= 10'(MIN_WAIT) && rf_ready) begin
          state_d    = S_RESP;
          rsp_data_d = rf_rdata;
          for (int k = 0; k < NUM_REQ; k++)
            if (2'(k) == gnt_q) rsp_valid_d[k] = 1'b1;
        end else if (wcnt_q == 10'(TIMEOUT)) begin
          state_d    = S_RESP;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          for (int k = 0; k < NUM_REQ; k++)
            if (2'(k) == gnt_q) rsp_valid_d[k] = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 10'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_q      <= 2'(NUM_REQ - 1);
      gnt_q       <= '0;
      scnt_q      <= '0;
      wcnt_q      <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
      rf_inst_q   <= '0;
      rf_cs_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      scnt_q      <= scnt_d;
      wcnt_q      <= wcnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rf_addr_q   <= rf_addr_d;
      rf_data_q   <= rf_data_d;
      rf_inst_q   <= rf_inst_d;
      rf_cs_q     <= rf_cs_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign rf_addr   = rf_addr_q;
  assign rf_data   = rf_data_q;
  assign rf_inst   = rf_inst_q;
  assign rf_cs     = rf_cs_q;
  assign busy      = busy_q;

endmodule
